// File: rtl/seg_capture_pkg.sv
// Shared constants, types and helpers for the seven-segment scan capture block.
package seg_capture_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned AN_W       = 4;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SLOT_W     = 2;
  localparam int unsigned VALUE_W    = 14;
  localparam int unsigned CNT_W      = 8;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [AN_W-1:0] AN_D0 = 4'b1110;
  localparam logic [AN_W-1:0] AN_D1 = 4'b1101;
  localparam logic [AN_W-1:0] AN_D2 = 4'b1011;
  localparam logic [AN_W-1:0] AN_D3 = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HELD
  } state_t;

  typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] bcd_digits_t;

  function automatic logic an_legal(input logic [AN_W-1:0] an);
    return (an == AN_D0) || (an == AN_D1) || (an == AN_D2) || (an == AN_D3);
  endfunction

  function automatic logic [SLOT_W-1:0] an_index(input logic [AN_W-1:0] an);
    logic [SLOT_W-1:0] idx;
    case (an)
      AN_D1:   idx = SLOT_W'(1);
      AN_D2:   idx = SLOT_W'(2);
      AN_D3:   idx = SLOT_W'(3);
      default: idx = SLOT_W'(0);
    endcase
    return idx;
  endfunction

  // Four BCD digits to binary; the maximum 9999 fits in VALUE_W bits.
  function automatic logic [VALUE_W-1:0] bcd_value(input bcd_digits_t d);
    return VALUE_W'(d[3]) * VALUE_W'(1000)
         + VALUE_W'(d[2]) * VALUE_W'(100)
         + VALUE_W'(d[1]) * VALUE_W'(10)
         + VALUE_W'(d[0]);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Active-low seven-segment pattern to BCD decoder with an invalid flag.
// SEG_CAPTURE_BLANK_EN: when defined, the all-off pattern decodes as 0.
module seg7_decode
  import seg_capture_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic             invalid_c,
  output logic [BCD_W-1:0] bcd_c
);

  always_comb begin
    invalid_c = 1'b0;
    bcd_c     = '0;
    case (seg)
      SEG_0: bcd_c = BCD_W'(0);
      SEG_1: bcd_c = BCD_W'(1);
      SEG_2: bcd_c = BCD_W'(2);
      SEG_3: bcd_c = BCD_W'(3);
      SEG_4: bcd_c = BCD_W'(4);
      SEG_5: bcd_c = BCD_W'(5);
      SEG_6: bcd_c = BCD_W'(6);
      SEG_7: bcd_c = BCD_W'(7);
      SEG_8: bcd_c = BCD_W'(8);
      SEG_9: bcd_c = BCD_W'(9);
`ifdef SEG_CAPTURE_BLANK_EN
      // Leading-zero blanking shows nothing for a zero digit
      SEG_BLANK: bcd_c = BCD_W'(0);
`endif
      default: invalid_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Recovers BCD digits and their binary value from a multiplexed 4-digit
// seven-segment bus. SEG_CAPTURE_BLANK_EN selects blank-as-zero decoding.
module seg_scan_capture
  import seg_capture_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AN_W-1:0]             an_in,
  input  logic [SEG_W-1:0]            seg_in,
  output logic [NUM_DIGITS*BCD_W-1:0] digits,
  output logic [VALUE_W-1:0]          value,
  output logic                        frame_valid,
  output logic                        frame_err
);

  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t             state, state_n;
  logic [AN_W-1:0]    ref_an, ref_an_n;
  logic [SEG_W-1:0]   ref_seg, ref_seg_n;
  logic [CNT_W-1:0]   count, count_n;
  logic [NUM_DIGITS-1:0] mask, mask_n;
  logic               err, err_n;
  bcd_digits_t        staged, staged_n;
  logic               commit_v, commit_v_n;
  logic               commit_e, commit_e_n;

  logic               an_ok_c;
  logic               start_c;
  logic               capture_c;
  logic [SLOT_W-1:0]  slot_c;
  logic               dec_invalid_c;
  logic [BCD_W-1:0]   dec_bcd_c;

  assign an_ok_c = an_legal(an_in);
  assign slot_c  = an_index(an_in);

  seg7_decode u_decode (
    .seg       (seg_in),
    .invalid_c (dec_invalid_c),
    .bcd_c     (dec_bcd_c)
  );

  // Dwell qualification: one capture per stable run of SETTLE identical samples
  always_comb begin
    state_n   = state;
    ref_an_n  = ref_an;
    ref_seg_n = ref_seg;
    count_n   = count;
    start_c   = 1'b0;
    capture_c = 1'b0;
    unique case (state)
      ST_IDLE: begin
        count_n = '0;
        start_c = an_ok_c;
      end
      ST_SETTLE: begin
        if (!an_ok_c) begin
          state_n = ST_IDLE;
          count_n = '0;
        end else if ((an_in == ref_an) && (seg_in == ref_seg)) begin
          count_n = count + CNT_ONE;
          if (count_n == SETTLE_CNT) begin
            capture_c = 1'b1;
            state_n   = ST_HELD;
          end
        end else begin
          start_c = 1'b1;
        end
      end
      ST_HELD: begin
        if (an_in != ref_an) begin
          if (an_ok_c) begin
            start_c = 1'b1;
          end else begin
            state_n = ST_IDLE;
            count_n = '0;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        count_n = '0;
      end
    endcase

    // A new dwell (from idle or an anode change) counts its first sample now
    if (start_c) begin
      ref_an_n  = an_in;
      ref_seg_n = seg_in;
      count_n   = CNT_ONE;
      if (SETTLE_CNT == CNT_ONE) begin
        capture_c = 1'b1;
        state_n   = ST_HELD;
      end else begin
        state_n = ST_SETTLE;
      end
    end
  end

  // Staging: write the slot, and hand a completed frame to the commit stage
  always_comb begin
    staged_n   = staged;
    mask_n     = mask;
    err_n      = err;
    commit_v_n = 1'b0;
    commit_e_n = 1'b0;
    if (capture_c) begin
      staged_n[slot_c] = dec_invalid_c ? '0 : dec_bcd_c;
      mask_n[slot_c]   = 1'b1;
      err_n            = err | dec_invalid_c;
      if (&mask_n) begin
        commit_v_n = ~err_n;
        commit_e_n = err_n;
        mask_n     = '0;
        err_n      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ref_an   <= '1;
      ref_seg  <= '1;
      count    <= '0;
      mask     <= '0;
      err      <= 1'b0;
      staged   <= '0;
      commit_v <= 1'b0;
      commit_e <= 1'b0;
    end else begin
      state    <= state_n;
      ref_an   <= ref_an_n;
      ref_seg  <= ref_seg_n;
      count    <= count_n;
      mask     <= mask_n;
      err      <= err_n;
      staged   <= staged_n;
      commit_v <= commit_v_n;
      commit_e <= commit_e_n;
    end
  end

  // Commit stage: staging still holds the finished frame; a capture this
  // same cycle lands in staging only after these outputs sample it.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits      <= '0;
      value       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= commit_v;
      frame_err   <= commit_e;
      if (commit_v) begin
        digits <= staged;
        value  <= bcd_value(staged);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Randomised and directed bench for seg_scan_capture at SETTLE = 1, 2 and 3,
// checked every cycle against a dwell/run-length model of the capture rules.
`timescale 1ns/1ps
module tb_seg_scan_capture;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] dig [NI];
  logic [13:0] val [NI];
  logic        fv  [NI];
  logic        fe  [NI];

  always #5 clk = ~clk;

  seg_scan_capture #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .an_in(an), .seg_in(seg),
    .digits(dig[0]), .value(val[0]), .frame_valid(fv[0]), .frame_err(fe[0]));
  seg_scan_capture #(.SETTLE(2)) dut2 (
    .clk(clk), .rst(rst), .an_in(an), .seg_in(seg),
    .digits(dig[1]), .value(val[1]), .frame_valid(fv[1]), .frame_err(fe[1]));
  seg_scan_capture #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .an_in(an), .seg_in(seg),
    .digits(dig[2]), .value(val[2]), .frame_valid(fv[2]), .frame_err(fe[2]));

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0d (0x%0h), expected %0d (0x%0h)",
                  name, idx, act, act, exp, exp);
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int dec(input logic [6:0] s);
    for (int d = 0; d < 10; d++) if (enc(d) == s) return d;
`ifdef SEG_CAPTURE_BLANK_EN
    if (s == 7'h7F) return 0;
`endif
    return -1;
  endfunction

  function automatic bit legal(input logic [3:0] a);
    return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
  endfunction

  function automatic int which(input logic [3:0] a);
    for (int k = 0; k < 4; k++) if (a[k] == 1'b0) return k;
    return 0;
  endfunction

  // Model: a dwell is a run of one legal anode; within it the first run of
  // (settle) identical segment samples is captured, and nothing more.
  logic [3:0] m_prev [NI];
  logic [6:0] m_rseg [NI];
  int         m_run  [NI];
  bit         m_capd [NI];
  int         m_slot [NI][4];
  bit   [3:0] m_mask [NI];
  bit         m_err  [NI];
  bit         m_pv   [NI];
  bit         m_pe   [NI];
  int         m_pdig [NI][4];
  int         e_dig  [NI][4];
  int         e_val  [NI];
  bit         e_fv   [NI];
  bit         e_fe   [NI];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_prev[i] = 4'hF; m_run[i] = 0; m_capd[i] = 1'b0; m_rseg[i] = 7'h7F;
        m_mask[i] = 4'h0; m_err[i] = 1'b0; m_pv[i] = 1'b0; m_pe[i] = 1'b0;
        e_fv[i] = 1'b0; e_fe[i] = 1'b0; e_val[i] = 0;
        for (int k = 0; k < 4; k++) begin
          m_slot[i][k] = 0; m_pdig[i][k] = 0; e_dig[i][k] = 0;
        end
      end else begin
        e_fv[i] = m_pv[i];
        e_fe[i] = m_pe[i];
        if (m_pv[i]) begin
          for (int k = 0; k < 4; k++) e_dig[i][k] = m_pdig[i][k];
          e_val[i] = e_dig[i][3] * 1000 + e_dig[i][2] * 100 + e_dig[i][1] * 10 + e_dig[i][0];
        end
        m_pv[i] = 1'b0;
        m_pe[i] = 1'b0;
        if (legal(an)) begin
          if (an != m_prev[i]) begin
            m_capd[i] = 1'b0; m_run[i] = 1; m_rseg[i] = seg;
          end else if (!m_capd[i]) begin
            if (seg == m_rseg[i]) m_run[i]++;
            else begin m_run[i] = 1; m_rseg[i] = seg; end
          end
          if (!m_capd[i] && m_run[i] == i + 1) begin
            int k; int d;
            m_capd[i] = 1'b1;
            k = which(an);
            d = dec(seg);
            if (d < 0) begin m_slot[i][k] = 0; m_err[i] = 1'b1; end
            else m_slot[i][k] = d;
            m_mask[i][k] = 1'b1;
            if (m_mask[i] == 4'hF) begin
              m_pv[i] = !m_err[i];
              m_pe[i] = m_err[i];
              for (int j = 0; j < 4; j++) m_pdig[i][j] = m_slot[i][j];
              m_mask[i] = 4'h0;
              m_err[i]  = 1'b0;
            end
          end
        end else begin
          m_run[i]  = 0;
          m_capd[i] = 1'b0;
        end
        m_prev[i] = an;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        check("digits", i, 32'(dig[i]),
              32'(e_dig[i][3] * 4096 + e_dig[i][2] * 256 + e_dig[i][1] * 16 + e_dig[i][0]));
        check("value", i, 32'(val[i]), 32'(e_val[i]));
        check("frame_valid", i, 32'(fv[i]), 32'(e_fv[i]));
        check("frame_err", i, 32'(fe[i]), 32'(e_fe[i]));
      end
    end
  end

  // Pulse bookkeeping, sampled before each edge's updates
  int fv_cnt [NI];
  int fe_cnt [NI];
  int cyc = 0;
  int fv_times [$];
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (fv[i] === 1'b1) fv_cnt[i]++;
      if (fe[i] === 1'b1) fe_cnt[i]++;
    end
    if (fv[1] === 1'b1) fv_times.push_back(cyc);
  end

  int b_fv [NI];
  int b_fe [NI];
  task automatic snap();
    for (int i = 0; i < NI; i++) begin b_fv[i] = fv_cnt[i]; b_fe[i] = fe_cnt[i]; end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    repeat (n) begin
      @(negedge clk);
      an  = a;
      seg = s;
    end
  endtask

  task automatic dwell(input int k, input logic [6:0] s, input int n);
    logic [3:0] a;
    a = 4'hF;
    a[k] = 1'b0;
    drive(a, s, n);
  endtask

  task automatic blank(input int n);
    drive(4'hF, 7'h7F, n);
  endtask

  task automatic scan(input logic [15:0] b, input int n, input bit ill);
    for (int k = 0; k < 4; k++) begin
      dwell(k, enc(int'(b[4*k +: 4])), n);
      if (ill) drive(4'b1100, enc(8), 2);
    end
  endtask

  task automatic rand_phase(input int frames);
    for (int f = 0; f < frames; f++) begin
      logic [15:0] b;
      for (int k = 0; k < 4; k++) b[4*k +: 4] = 4'($urandom_range(0, 9));
      for (int k = 0; k < 4; k++) begin
        int kk;
        logic [6:0] s;
        kk = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : k;
        s  = ($urandom_range(0, 15) == 0) ? 7'($urandom) : enc(int'(b[4*k +: 4]));
        if ($urandom_range(0, 3) == 0) dwell(kk, 7'($urandom), int'($urandom_range(1, 2)));
        dwell(kk, s, int'($urandom_range(1, 6)));
        if ($urandom_range(0, 4) == 0) drive(4'($urandom), enc(1), int'($urandom_range(1, 2)));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    an  = 4'hF;
    seg = 7'h7F;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < NI; i++) begin
      check("reset_digits", i, 32'(dig[i]), 32'h0);
      check("reset_value", i, 32'(val[i]), 32'd0);
    end
    rst = 1'b0;

    // Normal scan 0,0,4,2
    snap();
    scan(16'h0042, 4, 1'b0);
    blank(4);
    for (int i = 0; i < NI; i++) begin
      check("normal_digits", i, 32'(dig[i]), 32'h0042);
      check("normal_value", i, 32'(val[i]), 32'd42);
      check("normal_pulses", i, 32'(fv_cnt[i] - b_fv[i]), 32'd1);
    end
    check("model_value", 1, 32'(e_val[1]), 32'd42);

    // Undecodable (blank) pattern on digit 2
    snap();
    dwell(0, enc(2), 4);
    dwell(1, enc(4), 4);
    dwell(2, 7'h7F, 4);
    dwell(3, enc(9), 4);
    blank(4);
`ifdef SEG_CAPTURE_BLANK_EN
    check("blank_value", 1, 32'(val[1]), 32'd9042);
    check("blank_digits", 1, 32'(dig[1]), 32'h9042);
    check("blank_valid", 1, 32'(fv_cnt[1] - b_fv[1]), 32'd1);
    check("blank_err", 1, 32'(fe_cnt[1] - b_fe[1]), 32'd0);
`else
    check("blank_value", 1, 32'(val[1]), 32'd42);
    check("blank_digits", 1, 32'(dig[1]), 32'h0042);
    check("blank_valid", 1, 32'(fv_cnt[1] - b_fv[1]), 32'd0);
    check("blank_err", 1, 32'(fe_cnt[1] - b_fe[1]), 32'd1);
`endif

    // Glitch filter on digit 1: 2 samples of code 2 then 3 of code 5
    dwell(0, enc(2), 4);
    dwell(1, 7'h24, 2);
    dwell(1, 7'h12, 3);
    dwell(2, enc(0), 4);
    dwell(3, enc(0), 4);
    blank(4);
    check("glitch_digits", 2, 32'(dig[2]), 32'h0052);
    check("glitch_value", 2, 32'(val[2]), 32'd52);
    check("glitch_digits", 1, 32'(dig[1]), 32'h0022);

    // Illegal anode between dwells
    snap();
    scan(16'h5678, 4, 1'b1);
    blank(4);
    for (int i = 0; i < NI; i++) begin
      check("illegal_an_value", i, 32'(val[i]), 32'd5678);
      check("illegal_an_pulses", i, 32'(fv_cnt[i] - b_fv[i]), 32'd1);
    end

    // Continuous scan of 9999, three frames
    snap();
    fv_times.delete();
    repeat (3) scan(16'h9999, 4, 1'b0);
    blank(4);
    for (int i = 0; i < NI; i++) begin
      check("cont_pulses", i, 32'(fv_cnt[i] - b_fv[i]), 32'd3);
      check("cont_value", i, 32'(val[i]), 32'd9999);
    end
    check("cont_times", 1, 32'(fv_times.size()), 32'd3);
    if (fv_times.size() == 3) begin
      check("cont_gap1", 1, 32'(fv_times[1] - fv_times[0]), 32'd16);
      check("cont_gap2", 1, 32'(fv_times[2] - fv_times[1]), 32'd16);
    end

    // Reset after two captures
    dwell(0, enc(7), 4);
    dwell(1, enc(6), 4);
    @(negedge clk);
    rst = 1'b1;
    an  = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check("midrst_digits", i, 32'(dig[i]), 32'h0);
      check("midrst_value", i, 32'(val[i]), 32'd0);
    end
    snap();
    scan(16'h1234, 4, 1'b0);
    blank(4);
    for (int i = 0; i < NI; i++) begin
      check("post_rst_value", i, 32'(val[i]), 32'd1234);
      check("post_rst_pulses", i, 32'(fv_cnt[i] - b_fv[i]), 32'd1);
    end
    check("model_post_rst", 2, 32'(e_val[2]), 32'd1234);

    // Randomised traffic: dwell lengths, glitches, stray anodes, bad codes
    rand_phase(60);
    blank(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Receive-side counterpart of the four-digit time-division-multiplexed seven-segment driver. Samples the active-low anode bus and segment bus, qualifies each digit dwell, and decodes segment patterns back to BCD. Reassembles the four digits into a binary value and flags each completed scan frame. Used for loopback self-test and for bench scoreboarding of display paths.

## Interface
Parameters:
- SETTLE, default 2: consecutive identical AN/seg samples required before a digit is captured (range 1–255).

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- an_in  input  4  sampled anode bus, active-low; bit k low selects digit k (0 = ones).
- seg_in  input  7  sampled segment bus, active-low, bit order {g,f,e,d,c,b,a}.
- digits  output  16  captured BCD digits {d3,d2,d1,d0}.
- value  output  14  d3·1000 + d2·100 + d1·10 + d0, range 0–9999.
- frame_valid  output  1  one-cycle pulse: new digits/value committed.
- frame_err  output  1  one-cycle pulse: frame completed with an undecodable digit; outputs not updated.

## Operation
- Segment codes (active-low, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. Any other pattern is invalid.
- an_in is legal only when exactly one bit is 0. Any other pattern is treated as blank: state returns to IDLE and the settle count clears. Mask and staged digits are kept.
- States:
  - IDLE: wait for a legal an_in; on one, load the reference AN/seg, set count=1, go to SETTLE.
  - SETTLE: if the sample equals the reference, count++. Otherwise reload the reference with count=1. When count reaches SETTLE, capture and go to HELD. With SETTLE=1, capture happens on the first legal sample.
  - HELD: ignore further samples while an_in is unchanged. An an_in change (legal or blank) returns to IDLE handling in the same cycle.
  - Exactly one capture occurs per dwell.
- Capture:
  - Decode seg_in into staging slot k and set mask[k].
  - If the pattern is invalid, set the staging error bit and write 0 to the slot.
  - Re-capturing a slot that is already set overwrites that slot.
- Commit, when mask==4'b1111 after a capture:
  - Error bit clear: update digits and value, pulse frame_valid.
  - Error bit set: pulse frame_err only.
  - In both cases, clear mask and the error bit.
- Value arithmetic: 14-bit unsigned sum of constant multiplies; no overflow is possible.

## Timing
- Reset values: digits=0, value=0, frame_valid=0, frame_err=0, state IDLE, mask=0, error bit=0, count=0.
- Capture happens in the cycle in which the SETTLE-th identical sample is registered.
- digits, value and the pulse appear one cycle after the capture that completes the mask.
- frame_valid and frame_err are never asserted together. Each lasts exactly one cycle.
- A capture in the same cycle as a commit belongs to the next frame, so a back-to-back scan loses no digit.
- rst asserted mid-frame discards the mask and staging. Outputs return to their reset values on the next edge.

## Configuration
- SEG_CAPTURE_BLANK_EN:
  - Defined: seg_in=7F (all segments off) decodes as digit 0, so leading-zero-blanked displays capture cleanly.
  - Undefined: 7F is invalid and yields frame_err.

## Structure
- Shared package seg_capture_pkg holds:
  - the ten segment-code localparams,
  - SEG_BLANK (7'h7F),
  - the state enum {IDLE, SETTLE, HELD},
  - the legal anode constants 1110/1101/1011/0111.
- Sub-module seg7_decode: combinational seg[6:0] → {invalid, bcd[3:0]}. The blank-handling ifdef lives here.
- The top module holds the FSM, settle counter, mask, staging, and the commit/arithmetic register stage.

## Test plan
- Normal scan: SETTLE=2, drive digits 0,0,4,2 with 4 cycles dwell each → one frame_valid; digits=16'h0042, value=42.
- Glitch filter: SETTLE=3, on digit 1 apply seg=24 for 2 cycles then 12 for 3 cycles → slot 1 = 5, no capture from the 24 samples.
- Bad pattern: digit 2 seg=7F without SEG_CAPTURE_BLANK_EN → frame_err pulse; value holds its prior 42. With the macro defined → frame_valid and value=9042 when the other digits are 9,0,4,2.
- Illegal anode: an_in=1100 inserted between dwells → no capture, the frame still completes and value stays correct.
- Continuous scan of 9999 for 3 frames → three frame_valid pulses, each 16 cycles apart at a 4-cycle dwell.
- Reset mid-frame: rst for 1 cycle after 2 captures → outputs 0; the next full scan of 1234 yields value=1234.
